// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch FSM (IDLE/REQ/HOLD/FLUSH) with redirect and stall handling
// Optional FetchCount output when FETCH_COUNT_EN is defined.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] Instruction,
   output logic        InstrValid,
   output logic [31:0] PC,
`ifdef FETCH_COUNT_EN
   output logic [31:0] FetchCount,
`endif
   output logic [31:0] PCPlus4
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

   state_t      state;
   logic [31:0] pending;
   logic [31:0] target;
   logic        redirect;

   assign target   = BranchTarget & 32'hFFFF_FFFC;
   assign redirect = PCSrc && !Stall;
   assign IMemAddr = PC;
   assign PCPlus4  = PC + 32'd4;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= IDLE;
         PC          <= RESET_PC_ALIGNED;
         Instruction <= 32'd0;
         InstrValid  <= 1'b0;
         IMemReq     <= 1'b0;
         pending     <= 32'd0;
`ifdef FETCH_COUNT_EN
         FetchCount  <= 32'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state   <= REQ;
               IMemReq <= 1'b1;
            end
            REQ: begin
               if (redirect && IMemAck) begin
                  // Same-cycle ack is dropped; nothing left outstanding.
                  PC          <= target;
                  InstrValid  <= 1'b0;
                  Instruction <= 32'd0;
                  IMemReq     <= 1'b1;
               end else if (redirect) begin
                  pending     <= target;
                  InstrValid  <= 1'b0;
                  Instruction <= 32'd0;
                  state       <= FLUSH;
                  IMemReq     <= 1'b1;
               end else if (IMemAck) begin
                  Instruction <= IMemData;
                  InstrValid  <= 1'b1;
                  PC          <= PC + 32'd4;
`ifdef FETCH_COUNT_EN
                  FetchCount  <= FetchCount + 32'd1;
`endif
                  if (Stall) begin
                     state   <= HOLD;
                     IMemReq <= 1'b0;
                  end else begin
                     IMemReq <= 1'b1;
                  end
               end else if (InstrValid && Stall) begin
                  // Decode is blocked on a live instruction: stop requesting.
                  state   <= HOLD;
                  IMemReq <= 1'b0;
               end else begin
                  InstrValid <= 1'b0;
               end
            end
            HOLD: begin
               if (redirect) begin
                  PC          <= target;
                  InstrValid  <= 1'b0;
                  Instruction <= 32'd0;
                  state       <= REQ;
                  IMemReq     <= 1'b1;
               end else if (!Stall) begin
                  InstrValid <= 1'b0;
                  state      <= REQ;
                  IMemReq    <= 1'b1;
               end
            end
            FLUSH: begin
               InstrValid <= 1'b0;
               if (redirect)
                  pending <= target;
               if (IMemAck) begin
                  // Last accepted redirect wins, even in the ack cycle.
                  PC      <= redirect ? target : pending;
                  state   <= REQ;
                  IMemReq <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               IMemReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

   logic        Clk, Rst, Stall, PCSrc, IMemAck;
   logic [31:0] BranchTarget, IMemData;
   logic        IMemReq, InstrValid;
   logic [31:0] IMemAddr, Instruction, PC, PCPlus4;

   logic        ack2;
   logic        req2, valid2;
   logic [31:0] addr2, instr2, pc2, pc4_2;
`ifdef FETCH_COUNT_EN
   logic [31:0] fc, fc2;
`endif

   int tests = 0;
   int fails = 0;

   instruction_fetch u_dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
      .Instruction(Instruction), .InstrValid(InstrValid), .PC(PC),
`ifdef FETCH_COUNT_EN
      .FetchCount(fc),
`endif
      .PCPlus4(PCPlus4)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .Clk(Clk), .Rst(Rst), .Stall(1'b0), .PCSrc(1'b0), .BranchTarget(32'd0),
      .IMemReq(req2), .IMemAddr(addr2), .IMemAck(ack2), .IMemData(32'h1111_2222),
      .Instruction(instr2), .InstrValid(valid2), .PC(pc2),
`ifdef FETCH_COUNT_EN
      .FetchCount(fc2),
`endif
      .PCPlus4(pc4_2)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Clk = 0; Rst = 0; Stall = 0; PCSrc = 0; IMemAck = 0;
      BranchTarget = 32'd0; IMemData = 32'd0; ack2 = 0;
      #1 Rst = 1;
      #1;
      check("rst_req", {31'd0, IMemReq}, 32'd0);
      check("rst_pc", PC, 32'h0);
      check("rst_valid", {31'd0, InstrValid}, 32'd0);
      check("rst_instr", Instruction, 32'd0);
      check("rst_pc4", PCPlus4, 32'h4);
      check("rst_pc_wrap", pc2, 32'hFFFF_FFF8);
`ifdef FETCH_COUNT_EN
      check("rst_fc", fc, 32'd0);
`endif
      tick;
      Rst = 0;
      tick;
      // IDLE -> REQ
      check("first_req", {31'd0, IMemReq}, 32'd1);
      check("first_addr", IMemAddr, 32'h0);
      check("first_valid", {31'd0, InstrValid}, 32'd0);
      check("wrap_addr0", addr2, 32'hFFFF_FFF8);
      IMemAck = 1; IMemData = 32'h8C01_0004; ack2 = 1;
      tick;
      check("b2b_instr0", Instruction, 32'h8C01_0004);
      check("b2b_valid0", {31'd0, InstrValid}, 32'd1);
      check("b2b_addr1", IMemAddr, 32'h4);
      check("wrap_pc1", pc2, 32'hFFFF_FFFC);
      IMemData = 32'h0022_1820;
      tick;
      check("b2b_instr1", Instruction, 32'h0022_1820);
      check("b2b_pc", PC, 32'h8);
      check("b2b_pc4", PCPlus4, 32'hC);
      check("wrap_pc2", pc2, 32'h0);
      IMemAck = 0; ack2 = 0;
      // Redirect with request at 0x8 outstanding
      PCSrc = 1; BranchTarget = 32'h40;
      tick;
      check("fl_valid0", {31'd0, InstrValid}, 32'd0);
      check("fl_req0", {31'd0, IMemReq}, 32'd1);
      check("fl_addr0", IMemAddr, 32'h8);
      PCSrc = 0;
      tick;
      check("fl_valid1", {31'd0, InstrValid}, 32'd0);
      check("fl_addr1", IMemAddr, 32'h8);
      IMemAck = 1; IMemData = 32'hDEAD_BEEF;
      tick;
      check("fl_valid2", {31'd0, InstrValid}, 32'd0);
      check("fl_instr", Instruction, 32'd0);
      check("fl_newaddr", IMemAddr, 32'h40);
      // Stall at capture for 3 cycles
      IMemData = 32'h1000_0003; Stall = 1;
      tick;
      IMemAck = 0;
      for (int i = 0; i < 3; i++) begin
         check("st_req", {31'd0, IMemReq}, 32'd0);
         check("st_instr", Instruction, 32'h1000_0003);
         check("st_valid", {31'd0, InstrValid}, 32'd1);
         check("st_pc", PC, 32'h44);
         if (i == 2) Stall = 0;
         tick;
      end
      check("st_resume_req", {31'd0, IMemReq}, 32'd1);
      check("st_resume_addr", IMemAddr, 32'h44);
      check("st_resume_valid", {31'd0, InstrValid}, 32'd0);
      // Redirect in the ack cycle, unaligned target
      IMemAck = 1; IMemData = 32'h1234_5678; PCSrc = 1; BranchTarget = 32'h43;
      tick;
      check("rda_pc", PC, 32'h40);
      check("rda_instr", Instruction, 32'd0);
      check("rda_valid", {31'd0, InstrValid}, 32'd0);
      check("rda_req", {31'd0, IMemReq}, 32'd1);
      IMemAck = 0;
      // Redirect ignored while stalled
      Stall = 1; BranchTarget = 32'h80;
      tick;
      check("rds_pc", PC, 32'h40);
      check("rds_req", {31'd0, IMemReq}, 32'd1);
      Stall = 0; BranchTarget = 32'h100;
      tick;
      BranchTarget = 32'h200;
      tick;
      check("lw_addr_held", IMemAddr, 32'h40);
      PCSrc = 0; IMemAck = 1; IMemData = 32'hBBBB_0000;
      tick;
      check("lw_addr", IMemAddr, 32'h200);
      check("lw_valid", {31'd0, InstrValid}, 32'd0);
      IMemData = 32'hAAAA_0001;
      tick;
      check("cons_valid1", {31'd0, InstrValid}, 32'd1);
      check("cons_pc", PC, 32'h204);
      IMemAck = 0;
      tick;
      check("cons_valid0", {31'd0, InstrValid}, 32'd0);
      check("cons_req", {31'd0, IMemReq}, 32'd1);
`ifdef FETCH_COUNT_EN
      check("fc_count", fc, 32'd4);
`endif
      // Asynchronous reset mid-request
      Rst = 1;
      #1;
      check("ar_req", {31'd0, IMemReq}, 32'd0);
      check("ar_pc", PC, 32'h0);
      check("ar_instr", Instruction, 32'd0);
`ifdef FETCH_COUNT_EN
      check("ar_fc", fc, 32'd0);
`endif
      IMemAck = 1; IMemData = 32'h5555_5555;
      tick;
      Rst = 0;
      tick;
      check("ar_idle_valid", {31'd0, InstrValid}, 32'd0);
      check("ar_idle_instr", Instruction, 32'd0);
      check("ar_idle_req", {31'd0, IMemReq}, 32'd1);
      check("ar_idle_addr", IMemAddr, 32'h0);
      IMemAck = 0;
      tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
